// File: rtl/fir_decim_buf_if.sv
// Sample-in / averaged-out signal bundle for fir_decim_buf.
// DEPTH must match the DEPTH of the attached fir_decim_buf.
interface fir_decim_buf_if #(
  parameter int DEPTH = 4
) ();
  logic                     in_en;
  logic [9:0]               din;
  logic                     out_valid;
  logic                     out_ready;
  logic [9:0]               dout;
  logic [$clog2(DEPTH):0]   fill;
  logic                     overflow;

  modport master (
    output in_en, din, out_ready,
    input  out_valid, dout, fill, overflow
  );

  modport slave (
    input  in_en, din, out_ready,
    output out_valid, dout, fill, overflow
  );
endinterface

// File: rtl/fir_decim_buf.sv
// Decimating averager: sums DECIM accepted samples, pushes the truncated mean
// into a first-word-fall-through FIFO; drops and flags averages that find it full.
module fir_decim_buf #(
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fir_decim_buf_if.slave bus
);
  localparam int LGM = $clog2(DECIM);
  localparam int LGD = $clog2(DEPTH);

  logic [9+LGM:0] r_acc;
  logic [LGM-1:0] r_cnt;
  logic [9:0]     r_mem [DEPTH];
  logic [LGD-1:0] r_wr;
  logic [LGD-1:0] r_rd;
  logic [LGD:0]   r_fill;
  logic           r_ovf;

  logic [9+LGM:0] w_sum;
  logic [9:0]     w_avg;
  logic           w_last;
  logic           w_pop;
  logic           w_full;
  logic           w_wr_en;

  always_comb begin
    w_sum   = r_acc + {{LGM{1'b0}}, bus.din};
    w_avg   = w_sum[9+LGM:LGM];
    w_last  = bus.in_en && (r_cnt == LGM'(DECIM - 1));
    w_pop   = (r_fill != '0) && bus.out_ready;
    w_full  = (r_fill == (LGD+1)'(DEPTH));
    // A pop on the same edge frees the head slot, so a full FIFO still accepts.
    w_wr_en = w_last && (!w_full || w_pop);
  end

  always_comb begin
    bus.out_valid = (r_fill != '0);
    bus.dout      = (r_fill != '0) ? r_mem[r_rd] : '0;
    bus.fill      = r_fill;
    bus.overflow  = r_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_fill <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (bus.in_en) begin
        if (w_last) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_pop)   r_rd <= r_rd + 1'b1;
      if (w_wr_en && !w_pop)      r_fill <= r_fill + 1'b1;
      else if (!w_wr_en && w_pop) r_fill <= r_fill - 1'b1;
      if (w_last && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) r_mem[r_wr] <= w_avg;
  end
endmodule

// File: tb/tb_fir_decim_buf.sv
// Directed bench for fir_decim_buf with DECIM=4, DEPTH=4.
module tb_fir_decim_buf;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fir_decim_buf_if #(.DEPTH(4)) bus ();

  fir_decim_buf #(.DECIM(4), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input, then sample #1 after the active edge.
  task automatic step(input logic en, input logic [9:0] d);
    bus.in_en = en;
    bus.din   = d;
    @(posedge clk);
    #1;
    bus.in_en = 1'b0;
    bus.din   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_en = 1'b0;
    bus.din = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", bus.out_valid); end
    checks++; if (bus.dout !== 10'd0) begin errors++; $display("FAIL reset_dout got %0d exp 0", bus.dout); end
    checks++; if (bus.fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", bus.fill); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0d exp 0", bus.overflow); end
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    step(1, 100); step(1, 200); step(1, 300);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0d exp 0", bus.out_valid); end
    step(1, 400);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0d exp 1", bus.out_valid); end
    checks++; if (bus.dout !== 10'd250) begin errors++; $display("FAIL basic_dout got %0d exp 250", bus.dout); end
    checks++; if (bus.fill !== 3'd1) begin errors++; $display("FAIL basic_fill got %0d exp 1", bus.fill); end
    step(0, 0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_after_valid got %0d exp 0", bus.out_valid); end
    checks++; if (bus.dout !== 10'd0) begin errors++; $display("FAIL basic_after_dout got %0d exp 0", bus.dout); end
    checks++; if (bus.fill !== 3'd0) begin errors++; $display("FAIL basic_after_fill got %0d exp 0", bus.fill); end
  endtask

  task automatic test_truncate();
    bus.out_ready = 1'b1;
    step(1, 1); step(1, 1); step(1, 1); step(1, 2);
    checks++; if (bus.dout !== 10'd1) begin errors++; $display("FAIL trunc_dout got %0d exp 1", bus.dout); end
    step(0, 0);
    for (int i = 0; i < 4; i++) step(1, 1023);
    checks++; if (bus.dout !== 10'd1023) begin errors++; $display("FAIL max_dout got %0d exp 1023", bus.dout); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL max_ovf got %0d exp 0", bus.overflow); end
    step(0, 0);
  endtask

  task automatic test_gaps();
    bus.out_ready = 1'b1;
    step(1, 10); step(0, 0); step(1, 20); step(0, 0); step(1, 30); step(0, 0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL gaps_early_valid got %0d exp 0", bus.out_valid); end
    step(1, 40);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid got %0d exp 1", bus.out_valid); end
    checks++; if (bus.dout !== 10'd25) begin errors++; $display("FAIL gaps_dout got %0d exp 25", bus.dout); end
    step(0, 0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL gaps_single got %0d exp 0", bus.out_valid); end
  endtask

  task automatic test_overflow();
    logic [9:0] exp_v;
    bus.out_ready = 1'b0;
    for (int g = 1; g <= 5; g++)
      for (int s = 0; s < 4; s++) step(1, 10'(g));
    checks++; if (bus.fill !== 3'd4) begin errors++; $display("FAIL ovf_fill got %0d exp 4", bus.fill); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0d exp 1", bus.overflow); end
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      exp_v = 10'(k);
      checks++; if (bus.dout !== exp_v || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL ovf_drain%0d got %0d valid %0d exp %0d valid 1", k, bus.dout, bus.out_valid, exp_v);
      end
      step(0, 0);
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0d exp 0", bus.out_valid); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0d exp 1", bus.overflow); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_q [4];
    do_reset();
    bus.out_ready = 1'b0;
    for (int g = 1; g <= 4; g++)
      for (int s = 0; s < 4; s++) step(1, 10'(g));
    checks++; if (bus.fill !== 3'd4) begin errors++; $display("FAIL b2b_full got %0d exp 4", bus.fill); end
    step(1, 9); step(1, 9); step(1, 9);
    bus.out_ready = 1'b1;
    step(1, 9);
    checks++; if (bus.fill !== 3'd4) begin errors++; $display("FAIL b2b_fill got %0d exp 4", bus.fill); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %0d exp 0", bus.overflow); end
    exp_q[0] = 10'd2; exp_q[1] = 10'd3; exp_q[2] = 10'd4; exp_q[3] = 10'd9;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.dout !== exp_q[k] || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_drain%0d got %0d valid %0d exp %0d valid 1", k, bus.dout, bus.out_valid, exp_q[k]);
      end
      step(0, 0);
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", bus.out_valid); end
  endtask

  task automatic test_rst_mid();
    bus.out_ready = 1'b1;
    step(1, 500); step(1, 500);
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    step(1, 8); step(1, 8);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale got %0d exp 0", bus.out_valid); end
    step(1, 8); step(1, 8);
    checks++; if (bus.dout !== 10'd8 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_dout got %0d valid %0d exp 8 valid 1", bus.dout, bus.out_valid);
    end
    step(0, 0);
    checks++; if (bus.fill !== 3'd0) begin errors++; $display("FAIL rst_fill got %0d exp 0", bus.fill); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0d exp 0", bus.overflow); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.in_en = 1'b0;
    bus.din = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_truncate();
    test_gaps();
    test_overflow();
    test_back_to_back();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_decim_buf.md
FIR_DECIM_BUF -- requirements
Module: fir_decim_buf

Interface
REQ-001 Parameter DECIM, default 4: decimation ratio; power of two, 2..16.
REQ-002 Parameter DEPTH, default 4: output FIFO depth in entries; power of two, 2..16.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_en  input  1  din carries a valid filter output sample this cycle.
REQ-006 din  input  10  unsigned filter output sample.
REQ-007 out_valid  output  1  FIFO non-empty; dout holds the head entry.
REQ-008 out_ready  input  1  downstream accepts dout this cycle.
REQ-009 dout  output  10  unsigned decimated average, head of FIFO.
REQ-010 fill  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-011 overflow  output  1  sticky flag: at least one average dropped since reset.

Function
REQ-012 Accumulator SHALL be 10+log2(DECIM) bits wide, unsigned, and SHALL never wrap.
REQ-013 Sample counter SHALL count accepted samples 0..DECIM-1; a sample is accepted when in_en=1.
REQ-014 When in_en=0, accumulator and counter SHALL hold.
REQ-015 When in_en=1 and counter<DECIM-1: accumulator += din; counter += 1.
REQ-016 When in_en=1 and counter=DECIM-1: average = (accumulator+din) >> log2(DECIM), truncated (no rounding), pushed to FIFO; accumulator and counter cleared to 0 on the same edge.
REQ-017 Average result SHALL always fit in 10 bits; no saturation logic is needed.
REQ-018 FIFO SHALL be first-word-fall-through; out_valid=1 iff fill>0.
REQ-019 Latency: an average pushed on edge N SHALL appear on dout with out_valid=1 after edge N when the FIFO was empty.
REQ-020 dout SHALL be 0 whenever out_valid=0.
REQ-021 Pop SHALL occur on an edge where out_valid=1 and out_ready=1; the next entry, or 0 if none, SHALL appear after that edge.
REQ-022 out_ready while out_valid=0 SHALL have no effect.
REQ-023 Push and pop on the same edge SHALL both take effect; fill is unchanged. This includes fill=DEPTH, where the push is not dropped.
REQ-024 Push at fill=DEPTH without a simultaneous pop: the new average SHALL be dropped, FIFO contents unchanged, and overflow set to 1. The accumulator still clears per REQ-016.
REQ-025 overflow SHALL stay 1 until rst.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; order of entries SHALL be strictly preserved.
REQ-027 fill SHALL update on the same edge as each push or pop.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL set accumulator=0, counter=0, FIFO empty (pointers 0, fill=0), out_valid=0, dout=0, overflow=0.
REQ-029 rst SHALL take priority over in_en, push and pop in the same cycle.
REQ-030 A partially accumulated group SHALL be discarded by rst.
REQ-031 After rst deasserts, the first accepted sample SHALL start a new group at counter 0.

Verification (DECIM=4, DEPTH=4)
REQ-032 Feed din=100,200,300,400 with in_en=1 and out_ready=1 -> after the 4th edge, out_valid=1 and dout=250 for one cycle; then out_valid=0 and dout=0.
REQ-033 Feed din=1,1,1,2 -> dout=1 (sum 5, truncated); feed 1023 x4 -> dout=1023, overflow=0.
REQ-034 Feed din=10,_,20,_,30,_,40 with in_en low at the gaps -> a single average of 25 is produced, after the 40.
REQ-035 out_ready=0; feed 5 groups of constant values 1,2,3,4,5 -> fill=4, overflow=1; then out_ready=1 -> dout sequence 1,2,3,4, then out_valid=0; overflow remains 1.
REQ-036 FIFO full (fill=4) with out_ready=1 on the same edge a 5th average (value 9) is pushed -> fill stays 4, overflow=0, and 9 is drained last.
REQ-037 Feed din=500,500, assert rst for 1 cycle, then feed 8,8,8,8 -> dout=8, fill returns to 0 after the pop, overflow=0.
